// File: rtl/param_sort_pkg.sv
// rtl/param_sort_pkg.sv - shared types and constants for the parametrised in-place sorter
//
// Contents:
//   sort_state_e  FSM encoding (IDLE, SORT, FINISH)
//   SORT_ASC / SORT_DESC  values of the descending input
//   STATS_W       width of the optional swap counter (PARAM_SORT_STATS_EN builds)
//   sat_inc       saturating increment for the swap counter
package param_sort_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SORT   = 2'd1,
        FINISH = 2'd2
    } sort_state_e;

    localparam logic SORT_ASC  = 1'b0;
    localparam logic SORT_DESC = 1'b1;

    localparam int STATS_W = 16;

    // Counter sticks at all-ones instead of wrapping.
    function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
        return (&v) ? v : v + STATS_W'(1);
    endfunction

endpackage

// File: rtl/sort_cmp_swap.sv
// rtl/sort_cmp_swap.sv - combinational compare/exchange cell for one adjacent pair
//
// Ports:
//   a, b        current values at addresses j and j+1
//   descending  1 = larger value belongs at the lower address
//   lo_out      value to store at address j
//   hi_out      value to store at address j+1
//   swap        pair is out of order; equal values never swap (keeps the sort stable)
module sort_cmp_swap
    import param_sort_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              descending,
    output logic [DATA_W-1:0] lo_out,
    output logic [DATA_W-1:0] hi_out,
    output logic              swap
);

    always_comb begin
        swap = 1'b0;
        if (descending == SORT_DESC) begin
            swap = (a < b);
        end else begin
            swap = (a > b);
        end
        lo_out = swap ? b : a;
        hi_out = swap ? a : b;
    end

endmodule

// File: rtl/param_sort_ctrl.sv
// rtl/param_sort_ctrl.sv - parametrised in-place bubble sorter with register-array storage
//
// Host loads the array with wr_en while idle, pulses start, waits for done, then
// reads back through the registered rd port. One adjacent pair is compared per
// cycle; each pass is one shorter than the last and the sort stops early after a
// pass with no swaps.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset (clears the array too)
//   start, descending   sort request (sampled in IDLE) and direction (latched on start)
//   wr_en/addr/data     load port, ignored while busy; out-of-range addresses dropped
//   rd_addr, rd_data    readback, one cycle latency; out-of-range reads return 0
//   busy, done          busy while sorting; done held until next start or accepted write
//   swap_count          saturating swap counter, present only when PARAM_SORT_STATS_EN
//                       is defined
module param_sort_ctrl
    import param_sort_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              descending,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
`ifdef PARAM_SORT_STATS_EN
    output logic              done,
    output logic [STATS_W-1:0] swap_count
`else
    output logic              done
`endif
);

    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_SORT   = 2'(SORT);
    localparam logic [1:0] ST_FINISH = 2'(FINISH);

    // One extra bit so DEPTH itself (up to 256) is representable for range checks.
    localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LIMIT_INIT = ADDR_W'((DEPTH > 1) ? DEPTH - 2 : 0);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [1:0]        state;
    logic [ADDR_W-1:0] j;
    logic [ADDR_W-1:0] limit;
    logic              pass_swapped;
    logic              dir;

    logic [ADDR_W-1:0] j1;
    logic              wr_ok;
    logic              rd_ok;
    logic [DATA_W-1:0] lo_out;
    logic [DATA_W-1:0] hi_out;
    logic              swap_now;

    assign j1    = j + ADDR_W'(1);
    assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_C);
    assign rd_ok = ({1'b0, rd_addr} < DEPTH_C);

    sort_cmp_swap #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .a          (mem[j]),
        .b          (mem[j1]),
        .descending (dir),
        .lo_out     (lo_out),
        .hi_out     (hi_out),
        .swap       (swap_now)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state        <= ST_IDLE;
            j            <= '0;
            limit        <= '0;
            pass_swapped <= 1'b0;
            dir          <= SORT_ASC;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // The write and the start can share an edge: the sort starts on
                    // the next cycle and so already sees the written value.
                    if (wr_ok) begin
                        mem[wr_addr] <= wr_data;
                        done         <= 1'b0;
                    end
                    if (start) begin
                        dir          <= descending;
                        j            <= '0;
                        limit        <= LIMIT_INIT;
                        pass_swapped <= 1'b0;
                        done         <= 1'b0;
                        busy         <= 1'b1;
                        state        <= (DEPTH == 1) ? ST_FINISH : ST_SORT;
                    end
                end

                ST_SORT: begin
                    if (swap_now) begin
                        mem[j]       <= lo_out;
                        mem[j1]      <= hi_out;
                        pass_swapped <= 1'b1;
                    end
                    if (j != limit) begin
                        j <= j1;
                    end else if ((limit == '0) || !(pass_swapped || swap_now)) begin
                        // Either the last (single-pair) pass or a pass that changed
                        // nothing: the array is in order.
                        state <= ST_FINISH;
                    end else begin
                        // New pass; the largest-out-of-place element is now parked
                        // at the old limit+1, so the next pass can be one shorter.
                        j            <= '0;
                        limit        <= limit - ADDR_W'(1);
                        pass_swapped <= 1'b0;
                    end
                end

                ST_FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_ok ? mem[rd_addr] : '0;
        end
    end

`ifdef PARAM_SORT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            swap_count <= '0;
        end else if ((state == ST_IDLE) && start) begin
            swap_count <= '0;
        end else if ((state == ST_SORT) && swap_now) begin
            swap_count <= sat_inc(swap_count);
        end
    end
`endif

endmodule

// File: tb/tb_param_sort_ctrl.sv
// tb/tb_param_sort_ctrl.sv - self-checking bench for param_sort_ctrl (DEPTH 8, 1 and 16 builds)
module tb_param_sort_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // DEPTH 8 / DATA_W 8
    logic       st8 = 1'b0, ds8 = 1'b0, we8 = 1'b0;
    logic [2:0] wa8 = '0, ra8 = '0;
    logic [7:0] wd8 = '0, rd8;
    logic       busy8, done8;
    // DEPTH 1 / DATA_W 8
    logic       st1 = 1'b0, ds1 = 1'b0, we1 = 1'b0;
    logic [0:0] wa1 = '0, ra1 = '0;
    logic [7:0] wd1 = '0, rd1;
    logic       busy1, done1;
    // DEPTH 16 / DATA_W 12
    logic        st16 = 1'b0, ds16 = 1'b0, we16 = 1'b0;
    logic [3:0]  wa16 = '0, ra16 = '0;
    logic [11:0] wd16 = '0, rd16;
    logic        busy16, done16;
`ifdef PARAM_SORT_STATS_EN
    logic [15:0] sc8, sc1, sc16;
`endif

    param_sort_ctrl #(.DATA_W(8), .DEPTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .descending(ds8),
        .wr_en(we8), .wr_addr(wa8), .wr_data(wd8), .rd_addr(ra8), .rd_data(rd8),
        .busy(busy8),
`ifdef PARAM_SORT_STATS_EN
        .swap_count(sc8),
`endif
        .done(done8)
    );

    param_sort_ctrl #(.DATA_W(8), .DEPTH(1)) u1 (
        .clk(clk), .rst(rst), .start(st1), .descending(ds1),
        .wr_en(we1), .wr_addr(wa1), .wr_data(wd1), .rd_addr(ra1), .rd_data(rd1),
        .busy(busy1),
`ifdef PARAM_SORT_STATS_EN
        .swap_count(sc1),
`endif
        .done(done1)
    );

    param_sort_ctrl #(.DATA_W(12), .DEPTH(16)) u16 (
        .clk(clk), .rst(rst), .start(st16), .descending(ds16),
        .wr_en(we16), .wr_addr(wa16), .wr_data(wd16), .rd_addr(ra16), .rd_data(rd16),
        .busy(busy16),
`ifdef PARAM_SORT_STATS_EN
        .swap_count(sc16),
`endif
        .done(done16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int depth_of(input int sel);
        return (sel == 0) ? 8 : (sel == 1) ? 1 : 16;
    endfunction

    task automatic drive(input int sel, input logic st, input logic dsc,
                         input logic we, input int wa, input int wd);
        case (sel)
            0: begin st8 = st; ds8 = dsc; we8 = we; wa8 = 3'(wa); wd8 = 8'(wd); end
            1: begin st1 = st; ds1 = dsc; we1 = we; wa1 = 1'(wa); wd1 = 8'(wd); end
            default: begin st16 = st; ds16 = dsc; we16 = we; wa16 = 4'(wa); wd16 = 12'(wd); end
        endcase
    endtask

    task automatic set_ra(input int sel, input int a);
        case (sel)
            0: ra8 = 3'(a);
            1: ra1 = 1'(a);
            default: ra16 = 4'(a);
        endcase
    endtask

    function automatic int get_rd(input int sel);
        return (sel == 0) ? int'(rd8) : (sel == 1) ? int'(rd1) : int'(rd16);
    endfunction
    function automatic int get_busy(input int sel);
        return (sel == 0) ? int'(busy8) : (sel == 1) ? int'(busy1) : int'(busy16);
    endfunction
    function automatic int get_done(input int sel);
        return (sel == 0) ? int'(done8) : (sel == 1) ? int'(done1) : int'(done16);
    endfunction
`ifdef PARAM_SORT_STATS_EN
    function automatic int get_swc(input int sel);
        return (sel == 0) ? int'(sc8) : (sel == 1) ? int'(sc1) : int'(sc16);
    endfunction
`endif

    // Reference: final order by stable rank, swaps = strict inversions,
    // passes = worst leftward displacement (+1 clean pass unless the passes run out).
    task automatic model(input int d, input int a[16], input bit desc,
                         output int srt[16], output int swaps, output int lat);
        int p;
        int npass;
        int cmps;
        p = 0;
        swaps = 0;
        for (int i = 0; i < 16; i++) srt[i] = 0;
        for (int i = 0; i < d; i++) begin
            int left;
            int rank;
            left = 0;
            rank = 0;
            for (int k = 0; k < d; k++) begin
                if (k < i && (desc ? (a[k] < a[i]) : (a[k] > a[i]))) left++;
                if ((desc ? (a[k] > a[i]) : (a[k] < a[i])) || (a[k] == a[i] && k < i)) rank++;
            end
            swaps += left;
            if (left > p) p = left;
            srt[rank] = a[i];
        end
        if (d == 1) begin
            lat = 1;
        end else begin
            npass = (p + 1 < d - 1) ? p + 1 : d - 1;
            cmps = 0;
            for (int k = 0; k < npass; k++) cmps += d - 1 - k;
            lat = cmps + 1;
        end
    endtask

    task automatic load(input int sel, input int vals[16]);
        for (int i = 0; i < depth_of(sel); i++) begin
            @(negedge clk);
            drive(sel, 1'b0, 1'b0, 1'b1, i, vals[i]);
        end
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic readback(input int sel, input int exp[16], input string tag);
        for (int i = 0; i < depth_of(sel); i++) begin
            @(negedge clk);
            set_ra(sel, i);
            @(posedge clk);
            #1;
            check($sformatf("%s_rd%0d", tag, i), get_rd(sel), exp[i]);
        end
    endtask

    // Returns cycles from the accepting edge until done is seen high.
    task automatic run_sort(input int sel, input bit desc, input bit inject,
                            input int rst_at, output int lat);
        bit fin;
        fin = 1'b0;
        @(negedge clk);
        drive(sel, 1'b1, desc, 1'b0, 0, 0);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, desc, 1'b0, 0, 0);
        lat = 0;
        while (!fin && lat < 2000) begin
            @(posedge clk);
            lat++;
            #1;
            if (rst_at == lat) begin
                rst = 1'b1;
                #1;
                check("midsort_rst_busy", get_busy(sel), 0);
                check("midsort_rst_done", get_done(sel), 0);
                fin = 1'b1;
            end else if (get_done(sel) != 0) begin
                fin = 1'b1;
            end else begin
                drive(sel, 1'b0, desc, 1'b0, 0, 0);
                if (inject && lat == 3) drive(sel, 1'b1, !desc, 1'b0, 0, 0);
                if (inject && lat == 5) drive(sel, 1'b0, desc, 1'b1, 0, 255);
            end
        end
        if (!fin) check("sort_timeout", 1, 0);
    endtask

    task automatic full_test(input int sel, input int vals[16], input bit desc,
                             input bit inject, input string tag);
        int srt[16];
        int swaps;
        int exp_lat;
        int lat;
        model(depth_of(sel), vals, desc, srt, swaps, exp_lat);
        load(sel, vals);
        run_sort(sel, desc, inject, -1, lat);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy"}, get_busy(sel), 0);
        check({tag, "_done"}, get_done(sel), 1);
`ifdef PARAM_SORT_STATS_EN
        check({tag, "_swaps"}, get_swc(sel), swaps);
`endif
        readback(sel, srt, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int v[16];
        int z[16];
        int lat;

        for (int i = 0; i < 16; i++) z[i] = 0;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        check("reset_rd", rd8, 0);
        rst = 1'b0;

        // Ascending load, descending sort: worst case 29 cycles
        for (int i = 0; i < 16; i++) v[i] = (i < 8) ? 10 * (i + 1) : 0;
        full_test(0, v, 1'b1, 1'b0, "rev8");
        // Same load, ascending sort: already sorted, 8 cycles
        full_test(0, v, 1'b0, 1'b0, "sorted8");

        // Duplicates
        v[0] = 5; v[1] = 9; v[2] = 5; v[3] = 1; v[4] = 9; v[5] = 0; v[6] = 3; v[7] = 3;
        full_test(0, v, 1'b1, 1'b0, "dups8");
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b1, 2, 7);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 1'b0, 0, 0);
        check("wr_clears_done", done8, 0);

        // start and wr_en while busy are ignored
        for (int i = 0; i < 8; i++) v[i] = 10 * (i + 1);
        full_test(0, v, 1'b1, 1'b1, "inject8");

        // Reset in the middle of a worst-case sort
        load(0, v);
        run_sort(0, 1'b1, 1'b0, 10, lat);
        @(negedge clk);
        rst = 1'b0;
        readback(0, z, "after_rst");
        full_test(0, v, 1'b1, 1'b0, "post_rst8");

        // Random contents, random direction, small value range for plenty of ties
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 8; i++) v[i] = (t < 3) ? $urandom_range(0, 7) : $urandom_range(0, 255);
            full_test(0, v, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand8_%0d", t));
        end

        // DEPTH 1
        v[0] = $urandom_range(0, 255);
        full_test(1, v, 1'b1, 1'b0, "d1_desc");
        full_test(1, v, 1'b0, 1'b0, "d1_asc");

        // DEPTH 16, 12-bit data: reversed order needs 121 cycles
        for (int i = 0; i < 16; i++) v[i] = i;
        full_test(2, v, 1'b1, 1'b0, "rev16");
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 16; i++) v[i] = $urandom_range(0, 4095);
            full_test(2, v, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rand16_%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
